// File: rtl/vmem0_map_if.sv
// Map-0 lookup/write bus between the map-0 stage and its neighbours.
interface vmem0_map_if;
   logic [23:13] mapi;
   logic [31:27] vma;
   logic         vm0rp;
   logic         vm0wp;
   logic [4:0]   vmap;
   logic         vm0busy;
   logic         vm0perr;

   modport master (
      output mapi, vma, vm0rp, vm0wp,
      input  vmap, vm0busy, vm0perr
   );

   modport slave (
      input  mapi, vma, vm0rp, vm0wp,
      output vmap, vm0busy, vm0perr
   );
endinterface

// File: rtl/vmem0_map.sv
// Map-0 table: 2048 x 5 page-group map, filled with 31 by a post-reset sweep.
// Optional per-entry even parity selected by VMEM0_PARITY_EN.
module vmem0_map (
   input logic          clk,
   input logic          reset,
   vmem0_map_if.slave   bus
);

   localparam int unsigned AW    = 11;
   localparam int unsigned DW    = 5;
   localparam int unsigned DEPTH = 2048;
`ifdef VMEM0_PARITY_EN
   localparam int unsigned RW    = DW + 1;
`else
   localparam int unsigned RW    = DW;
`endif
   localparam logic [DW-1:0] FILL = 5'd31;

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t          state;
   logic [AW-1:0]   cnt;
   logic [RW-1:0]   ram [DEPTH];
   logic [DW-1:0]   vmap_q;
   logic            busy_q;
   logic            perr_q;

   logic            ram_we_c;
   logic [AW-1:0]   ram_wa_c;
   logic [DW-1:0]   ram_wd_c;
   logic [RW-1:0]   ram_word_c;
   logic [RW-1:0]   rd_c;
   logic            rd_perr_c;

   // Write port select: sweep owns the array in INIT, vm0wp in RUN.
   always_comb begin
      ram_we_c = 1'b0;
      ram_wa_c = cnt;
      ram_wd_c = FILL;
      if (state == ST_INIT) begin
         ram_we_c = 1'b1;
      end else if (bus.vm0wp) begin
         ram_we_c = 1'b1;
         ram_wa_c = bus.mapi;
         ram_wd_c = bus.vma;
      end
   end

   assign rd_c = ram[bus.mapi];

`ifdef VMEM0_PARITY_EN
   assign ram_word_c = {^ram_wd_c, ram_wd_c};
   assign rd_perr_c  = rd_c[DW] ^ (^rd_c[DW-1:0]);
`else
   assign ram_word_c = ram_wd_c;
   assign rd_perr_c  = 1'b0;
`endif

   // Array has no reset; the sweep provides its initial contents.
   always_ff @(posedge clk) begin
      if (ram_we_c && !reset)
         ram[ram_wa_c] <= ram_word_c;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_INIT;
         cnt    <= '0;
         vmap_q <= '0;
         perr_q <= 1'b0;
         busy_q <= 1'b1;
      end else begin
         case (state)
            ST_INIT: begin
               cnt <= cnt + AW'(1);
               if (cnt == AW'(DEPTH - 1)) begin
                  state  <= ST_RUN;
                  busy_q <= 1'b0;
               end
            end
            ST_RUN: begin
               // Simultaneous write takes priority and suppresses the read.
               if (bus.vm0rp && !bus.vm0wp) begin
                  vmap_q <= rd_c[DW-1:0];
                  perr_q <= rd_perr_c;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   assign bus.vmap    = vmap_q;
   assign bus.vm0busy = busy_q;
   assign bus.vm0perr = perr_q;

endmodule

// File: doc/vmem0_map.md
VMEM0_MAP -- requirements
Module: vmem0_map

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 mapi  input  11 [23:13]  map-0 lookup/write address; page-group bits of the virtual address.
REQ-005 vma  input  5 [31:27]  write data for map-0 entries.
REQ-006 vm0rp  input  1  read pulse; latch map-0 entry at mapi into vmap.
REQ-007 vm0wp  input  1  write pulse; store vma[31:27] at mapi.
REQ-008 vmap  output  5 [4:0]  registered map-0 entry; forms high bits of the map-1 address in the downstream map-1 stage.
REQ-009 vm0busy  output  1  high while the post-reset initialisation sweep runs.
REQ-010 vm0perr  output  1  registered parity error for the current vmap value.

Function
REQ-011 Storage SHALL be a 2048 x 5 array, or 2048 x 6 when parity is compiled in; one read or one write per cycle.
REQ-012 FSM states: INIT and RUN; reset forces INIT with sweep counter = 0.
REQ-013 INIT: each cycle writes fill value 5'd31 to ram[counter], then increments the counter; after writing address 2047 the FSM enters RUN on the next edge; sweep = exactly 2048 cycles.
REQ-014 vm0busy SHALL be 1 in INIT and 0 in RUN; it falls on the edge on which RUN is entered.
REQ-015 In INIT, vm0rp and vm0wp SHALL be ignored; vmap and vm0perr hold 0.
REQ-016 RUN, vm0wp=1: ram[mapi] <= vma[31:27] on that edge; vmap holds.
REQ-017 RUN, vm0rp=1 and vm0wp=0: vmap <= ram[mapi]; 1-cycle latency, with data visible after the same edge.
REQ-018 RUN, vm0rp=1 and vm0wp=1 together: write wins; no read; vmap and vm0perr hold.
REQ-019 A write followed by a read of the same address on the next cycle SHALL return the new data; no bypass is needed within one cycle because of REQ-018.
REQ-020 With neither pulse asserted, vmap and vm0perr SHALL hold.
REQ-021 mapi SHALL wrap-free index 0..2047; every address is valid; no out-of-range case exists.

Reset
REQ-022 On reset assertion: vmap=0, vm0perr=0, vm0busy=1, FSM=INIT, counter=0, all asynchronously.
REQ-023 Reset asserted mid-sweep or mid-RUN SHALL abort the current operation; the sweep restarts from address 0 after deassertion and re-fills all 2048 entries.
REQ-024 Array contents need no reset beyond the sweep.

Configuration
REQ-025 Macro VMEM0_PARITY_EN SHALL select parity.
REQ-026 With VMEM0_PARITY_EN defined, each entry stores an extra even-parity bit (XOR of the 5 data bits), written by both the sweep and vm0wp. On each RUN read, vm0perr <= parity mismatch of the entry read, registered with vmap. It is cleared by the next clean read.
REQ-027 Without VMEM0_PARITY_EN, the array is 5 bits wide, vm0perr is tied to 0, and all other behaviour is identical.

Verification
REQ-028 Reset pulse, then release -> vm0busy=1 for exactly 2048 cycles, then 0; reads of addresses 0, 1023 and 2047 return vmap=5'd31.
REQ-029 RUN: write 5'd7 to 11'h155 (vma[31:27]=7), read 11'h155 next cycle -> vmap=7 one edge after the read; a read of 11'h154 -> 31.
REQ-030 RUN: vm0rp=vm0wp=1 at 11'h010 with data 5'd3 -> vmap unchanged that edge; a following read of 11'h010 -> 3.
REQ-031 Assert reset at sweep cycle 1000, release -> vmap=0 immediately, busy for a full 2048 cycles again, previously written entries read 31.
REQ-032 vm0rp/vm0wp pulsed during INIT -> no effect; after the sweep, the targeted address still reads 31.
REQ-033 With VMEM0_PARITY_EN: the bench forces the parity bit of entry 11'h020 inverted, then reads it -> vm0perr=1; a read of 11'h021 -> vm0perr=0. Without the macro -> vm0perr is always 0.
